// File: rtl/branch_recovery_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | branch_recovery_ctrl_pkg: shared types and defaults for branch recovery   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

package branch_recovery_ctrl_pkg;

  typedef logic [63:0] xlen_t;

  typedef enum logic [1:0] {
    BR_IDLE     = 2'd0,
    BR_FLUSH    = 2'd1,
    BR_REDIRECT = 2'd2
  } br_rec_state_t;

  localparam int BR_FLUSH_CYCLES = 2;
  localparam int BR_CNT_W        = 4;

endpackage

`default_nettype wire

// File: rtl/branch_recovery_ctrl.sv
// +--------------------------------------------------------------------------+
// | branch_recovery_ctrl: commit-time mispredict flush/redirect sequencer.    |
// | Optional macro BR_RECOVERY_STATS_EN adds branch/mispredict counters.      |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module branch_recovery_ctrl
  import branch_recovery_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = BR_FLUSH_CYCLES
) (
  input  logic  clk,
  input  logic  rstn,
  input  logic  commit_br_valid_i,
  output logic  commit_br_ready_o,
  output logic  bq_pop_o,
  input  logic  bq_missprediction_i,
  input  xlen_t bq_pcnext_i,
  output logic  flush_o,
  output logic  redirect_valid_o,
  output xlen_t redirect_pc_o,
  input  logic  redirect_ready_i,
`ifdef BR_RECOVERY_STATS_EN
  output logic [63:0] stat_branches_o,
  output logic [63:0] stat_misp_o,
`endif
  output logic  busy_o
);

  br_rec_state_t       state_q, state_d;
  logic [BR_CNT_W-1:0] cnt_q, cnt_d;
  xlen_t               pc_q, pc_d;
  logic                ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    case (state_q)
      BR_IDLE: begin
        if (bq_pop_o && bq_missprediction_i) begin
          pc_d    = bq_pcnext_i & ~64'd1;
          cnt_d   = BR_CNT_W'(FLUSH_CYCLES - 1);
          state_d = BR_FLUSH;
        end
      end
      BR_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = BR_REDIRECT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      BR_REDIRECT: begin
        if (redirect_ready_i) begin
          state_d = BR_IDLE;
        end
      end
      default: state_d = BR_IDLE;
    endcase
    // Ready is registered so it holds 0 during reset and never depends on inputs.
    ready_d = (state_d == BR_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= BR_IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      ready_q <= ready_d;
    end
  end

  assign commit_br_ready_o = ready_q;
  assign bq_pop_o          = commit_br_valid_i & ready_q;
  assign flush_o           = (state_q == BR_FLUSH);
  assign redirect_valid_o  = (state_q == BR_REDIRECT);
  assign redirect_pc_o     = pc_q;
  assign busy_o            = (state_q != BR_IDLE);

`ifdef BR_RECOVERY_STATS_EN
  logic [63:0] stat_br_q, stat_misp_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_br_q   <= '0;
      stat_misp_q <= '0;
    end else begin
      if (bq_pop_o) begin
        stat_br_q <= stat_br_q + 64'd1;
      end
      if (bq_pop_o && bq_missprediction_i) begin
        stat_misp_q <= stat_misp_q + 64'd1;
      end
    end
  end

  assign stat_branches_o = stat_br_q;
  assign stat_misp_o     = stat_misp_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_branch_recovery_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_branch_recovery_ctrl: directed self-checking bench, FLUSH_CYCLES 2 & 1 |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_branch_recovery_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  int          total = 0;
  int          bad = 0;

  logic        v, m, rr, rdy, pop, fl, rv, busy;
  logic [63:0] pc, rpc;
  logic        v1, m1, rr1, rdy1, pop1, fl1, rv1, busy1;
  logic [63:0] pc1, rpc1;
`ifdef BR_RECOVERY_STATS_EN
  logic [63:0] sb, sm, sb1, sm1;
`endif

  always #5 clk = ~clk;

  branch_recovery_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .rstn(rstn),
    .commit_br_valid_i(v), .commit_br_ready_o(rdy), .bq_pop_o(pop),
    .bq_missprediction_i(m), .bq_pcnext_i(pc),
    .flush_o(fl), .redirect_valid_o(rv), .redirect_pc_o(rpc),
    .redirect_ready_i(rr),
`ifdef BR_RECOVERY_STATS_EN
    .stat_branches_o(sb), .stat_misp_o(sm),
`endif
    .busy_o(busy)
  );

  branch_recovery_ctrl #(.FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rstn(rstn),
    .commit_br_valid_i(v1), .commit_br_ready_o(rdy1), .bq_pop_o(pop1),
    .bq_missprediction_i(m1), .bq_pcnext_i(pc1),
    .flush_o(fl1), .redirect_valid_o(rv1), .redirect_pc_o(rpc1),
    .redirect_ready_i(rr1),
`ifdef BR_RECOVERY_STATS_EN
    .stat_branches_o(sb1), .stat_misp_o(sm1),
`endif
    .busy_o(busy1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    v = 0; m = 0; pc = '0; rr = 0;
    v1 = 0; m1 = 0; pc1 = '0; rr1 = 0;
    tick(); tick();
    total++; if (rdy !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", rdy); end
    total++; if ({fl, rv, busy, pop} !== 4'b0000) begin bad++; $display("FAIL rst_outs got=%b exp=0000", {fl, rv, busy, pop}); end
    total++; if (rpc !== 64'd0) begin bad++; $display("FAIL rst_pc got=%h exp=0", rpc); end
    rstn = 1'b1;
    tick();
    total++; if (rdy !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b exp=1", rdy); end
    total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL post_rst_ready1 got=%b exp=1", rdy1); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      v = 1; m = 0; pc = 64'h100 + 64'(i);
      #1;
      total++; if (pop !== 1'b1) begin bad++; $display("FAIL b2b_pop%0d got=%b exp=1", i, pop); end
      tick();
      total++; if ({fl, busy, rdy} !== 3'b001) begin bad++; $display("FAIL b2b_state%0d got=%b exp=001", i, {fl, busy, rdy}); end
    end
    v = 0;
    #1;
    total++; if (pop !== 1'b0) begin bad++; $display("FAIL b2b_idle_pop got=%b exp=0", pop); end
`ifdef BR_RECOVERY_STATS_EN
    total++; if (sb !== 64'd3) begin bad++; $display("FAIL b2b_stat got=%0d exp=3", sb); end
`endif
  endtask

  task automatic test_mispredict();
    tick();
    v = 1; m = 1; pc = 64'h8000_1235; rr = 1;
    #1;
    total++; if (pop !== 1'b1) begin bad++; $display("FAIL mp_pop got=%b exp=1", pop); end
    tick();
    v = 0; m = 0;
    total++; if ({fl, rv, busy, rdy} !== 4'b1010) begin bad++; $display("FAIL mp_c1 got=%b exp=1010", {fl, rv, busy, rdy}); end
    tick();
    total++; if ({fl, rv, busy, rdy} !== 4'b1010) begin bad++; $display("FAIL mp_c2 got=%b exp=1010", {fl, rv, busy, rdy}); end
    tick();
    total++; if ({fl, rv, busy, rdy} !== 4'b0110) begin bad++; $display("FAIL mp_c3 got=%b exp=0110", {fl, rv, busy, rdy}); end
    total++; if (rpc !== 64'h8000_1234) begin bad++; $display("FAIL mp_pc got=%h exp=80001234", rpc); end
    tick();
    total++; if ({fl, rv, busy, rdy} !== 4'b0001) begin bad++; $display("FAIL mp_c4 got=%b exp=0001", {fl, rv, busy, rdy}); end
    rr = 0;
`ifdef BR_RECOVERY_STATS_EN
    total++; if (sm !== 64'd1) begin bad++; $display("FAIL mp_stat got=%0d exp=1", sm); end
`endif
  endtask

  task automatic test_redirect_stall();
    v = 1; m = 1; pc = 64'h1_0000_0003; rr = 0;
    #1;
    total++; if (pop !== 1'b1) begin bad++; $display("FAIL st_pop got=%b exp=1", pop); end
    tick();
    m = 0; pc = 64'hdead_beef;
    for (int c = 1; c <= 2; c++) begin
      total++; if ({fl, rv, pop, rdy} !== 4'b1000) begin bad++; $display("FAIL st_flush%0d got=%b exp=1000", c, {fl, rv, pop, rdy}); end
      tick();
    end
    for (int c = 3; c <= 8; c++) begin
      if (c == 8) rr = 1;
      total++; if ({fl, rv, pop, rdy} !== 4'b0100) begin bad++; $display("FAIL st_rv%0d got=%b exp=0100", c, {fl, rv, pop, rdy}); end
      total++; if (rpc !== 64'h1_0000_0002) begin bad++; $display("FAIL st_pc%0d got=%h exp=100000002", c, rpc); end
      tick();
    end
    rr = 0;
    total++; if ({rv, busy, rdy, pop} !== 4'b0011) begin bad++; $display("FAIL st_back got=%b exp=0011", {rv, busy, rdy, pop}); end
    tick();
    v = 0;
`ifdef BR_RECOVERY_STATS_EN
    total++; if (sm !== 64'd2) begin bad++; $display("FAIL st_misp got=%0d exp=2", sm); end
    total++; if (sb !== 64'd6) begin bad++; $display("FAIL st_br got=%0d exp=6", sb); end
`endif
  endtask

  task automatic test_reset_mid_flush();
    v = 1; m = 1; pc = 64'h4444; rr = 0;
    tick();
    v = 0; m = 0;
    total++; if (fl !== 1'b1) begin bad++; $display("FAIL rmf_pre got=%b exp=1", fl); end
    rstn = 1'b0;
    #1;
    total++; if ({fl, rv, busy, rdy} !== 4'b0000) begin bad++; $display("FAIL rmf_async got=%b exp=0000", {fl, rv, busy, rdy}); end
    total++; if (rpc !== 64'd0) begin bad++; $display("FAIL rmf_pc got=%h exp=0", rpc); end
    tick();
    total++; if ({fl, busy} !== 2'b00) begin bad++; $display("FAIL rmf_next got=%b exp=00", {fl, busy}); end
`ifdef BR_RECOVERY_STATS_EN
    total++; if ({sb, sm} !== 128'd0) begin bad++; $display("FAIL rmf_stats got=%h exp=0", {sb, sm}); end
`endif
    rstn = 1'b1;
    tick();
    total++; if ({rdy, busy} !== 2'b10) begin bad++; $display("FAIL rmf_idle got=%b exp=10", {rdy, busy}); end
  endtask

  task automatic test_flush1();
    rr1 = 1;
    tick();
    rr1 = 0;
    total++; if ({busy1, rv1} !== 2'b00) begin bad++; $display("FAIL f1_idle_rr got=%b exp=00", {busy1, rv1}); end
    v1 = 1; m1 = 1; pc1 = 64'h5;
    tick();
    v1 = 0; m1 = 0; rr1 = 1;
    total++; if ({fl1, rv1, rdy1} !== 3'b100) begin bad++; $display("FAIL f1_c1 got=%b exp=100", {fl1, rv1, rdy1}); end
    tick();
    rr1 = 0;
    total++; if ({fl1, rv1, rdy1} !== 3'b010) begin bad++; $display("FAIL f1_c2 got=%b exp=010", {fl1, rv1, rdy1}); end
    total++; if (rpc1 !== 64'h4) begin bad++; $display("FAIL f1_pc got=%h exp=4", rpc1); end
    tick();
    rr1 = 1;
    total++; if ({fl1, rv1} !== 2'b01) begin bad++; $display("FAIL f1_c3 got=%b exp=01", {fl1, rv1}); end
    tick();
    rr1 = 0;
    total++; if ({rv1, busy1, rdy1} !== 3'b001) begin bad++; $display("FAIL f1_c4 got=%b exp=001", {rv1, busy1, rdy1}); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mispredict();
    test_redirect_stall();
    test_reset_mid_flush();
    test_flush1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/branch_recovery_ctrl.md
BRANCH_RECOVERY_CTRL -- requirements
Module: branch_recovery_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, number of cycles flush_o is held (legal 1..15).
REQ-002 SHALL have clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have commit_br_valid_i  input  1  ROB head is a branch ready to commit.
REQ-005 SHALL have commit_br_ready_o  output  1  controller accepts the branch commit.
REQ-006 SHALL have bq_pop_o  output  1  pops branch queue head; equals commit_br_valid_i & commit_br_ready_o.
REQ-007 SHALL have bq_missprediction_i  input  1  branch queue head misprediction flag.
REQ-008 SHALL have bq_pcnext_i  input  64  branch queue head resolved next PC.
REQ-009 SHALL have flush_o  output  1  flush all speculative state (ROB, issue, FUs, branch queue).
REQ-010 SHALL have redirect_valid_o  output  1  frontend redirect request.
REQ-011 SHALL have redirect_pc_o  output  64  redirect target.
REQ-012 SHALL have redirect_ready_i  input  1  frontend accepts redirect.
REQ-013 SHALL have busy_o  output  1  recovery in progress (state != IDLE).

Function
REQ-014 SHALL implement FSM states IDLE, FLUSH, REDIRECT.
REQ-015 commit_br_ready_o SHALL be 1 only in IDLE; commit is stalled in every other state.
REQ-016 IDLE: commit handshake with bq_missprediction_i=0 SHALL pop and stay IDLE; back-to-back correct branches retire one per cycle.
REQ-017 IDLE: commit handshake with bq_missprediction_i=1 SHALL pop, latch bq_pcnext_i into redirect_pc_o, load flush counter with FLUSH_CYCLES-1, go to FLUSH next cycle.
REQ-018 FLUSH: flush_o SHALL be 1 for exactly FLUSH_CYCLES consecutive cycles; counter decrements each cycle; at zero go to REDIRECT.
REQ-019 REDIRECT: redirect_valid_o SHALL be 1 and redirect_pc_o stable until redirect_ready_i=1; on that cycle go to IDLE.
REQ-020 redirect_pc_o SHALL have bit 0 forced to 0 when latched.
REQ-021 flush_o and redirect_valid_o SHALL never be 1 in the same cycle.
REQ-022 First possible new commit acceptance SHALL be the cycle after the redirect handshake (ready registered from state).
REQ-023 redirect_ready_i asserted outside REDIRECT SHALL be ignored.
REQ-024 Latency mispredict commit to first redirect_valid_o SHALL be FLUSH_CYCLES+1 cycles.
REQ-025 All outputs SHALL be registered or decoded only from state (no combinational path from inputs), except bq_pop_o.

Reset
REQ-026 Reset assertion SHALL take effect immediately, mid-recovery included: state IDLE, counter 0, redirect_pc_o 0.
REQ-027 Reset values SHALL be: flush_o 0, redirect_valid_o 0, busy_o 0, bq_pop_o 0, commit_br_ready_o 1 (only after rstn deasserted).
REQ-028 While rstn=0, commit_br_ready_o SHALL be 0.

Configuration
REQ-029 Macro BR_RECOVERY_STATS_EN SHALL add outputs stat_branches_o (64) and stat_misp_o (64): wrapping counters of popped branches and popped mispredicted branches, reset to 0.
REQ-030 Without BR_RECOVERY_STATS_EN these ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-031 State enum type br_rec_state_t and xlen_t SHALL live in shared package C; FLUSH_CYCLES default constant BR_FLUSH_CYCLES in C.
REQ-032 SHALL be a single module with no sub-module; the flush down-counter is inline.

Verification
REQ-033 Reset mid-FLUSH (cycle 1 of 2) -> next cycle flush_o=0, busy_o=0, state IDLE.
REQ-034 Three back-to-back correct commits -> bq_pop_o=1 three cycles, flush_o never 1, stat_branches_o=3 (stats enabled).
REQ-035 Mispredict commit, pcnext=0x8000_1235, FLUSH_CYCLES=2, redirect_ready_i=1 -> flush_o cycles +1,+2; redirect_valid_o cycle +3 with pc 0x8000_1234; ready_o=1 cycle +4.
REQ-036 Redirect with redirect_ready_i low 5 cycles -> redirect_valid_o held 6 cycles, pc stable, commit_br_ready_o=0 throughout.
REQ-037 commit_br_valid_i held high during recovery -> no bq_pop_o until IDLE; stat_misp_o increments exactly 1.
REQ-038 FLUSH_CYCLES=1, redirect_ready_i stray pulse during FLUSH -> ignored; single flush cycle then normal redirect.
